rf_write_queue: RTL and testbench

Writer-side front end for the 32x32 MIPS register file. It buffers completed ALU and load results and drains them one per granted cycle onto the register file write port (RegWrite, write_reg, write_data). It also provides youngest-match forwarding of pending values to the two read-address buses, so decode sees data that has not yet been written.

---
 rtl/rf_write_queue.sv | 124 ++++++++++++
 tb/tb_rf_write_queue.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/rf_write_queue.sv
// rf_write_queue: buffers completed ALU and load results and drains them
// one per granted cycle onto the register file write port. It also forwards
// the youngest pending value to two read-address buses.
module rf_write_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_reg,
  input  logic                     in_mem_to_reg,
  input  logic [DATA_W-1:0]        in_alu_result,
  input  logic [DATA_W-1:0]        in_mem_data,
  input  logic                     flush,
  input  logic                     wr_grant,
  output logic                     RegWrite,
  output logic [ADDR_W-1:0]        write_reg,
  output logic [DATA_W-1:0]        write_data,
  input  logic [ADDR_W-1:0]        fwd_reg1,
  input  logic [ADDR_W-1:0]        fwd_reg2,
  output logic                     fwd_hit1,
  output logic                     fwd_hit2,
  output logic [DATA_W-1:0]        fwd_data1,
  output logic [DATA_W-1:0]        fwd_data2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] ent_reg_q  [DEPTH];
  logic [ADDR_W-1:0] ent_reg_d  [DEPTH];
  logic [DATA_W-1:0] ent_data_q [DEPTH];
  logic [DATA_W-1:0] ent_data_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  logic push, pop;

  // Write-port view of the head entry; outputs read as zero when empty.
  always_comb begin
    count      = count_q;
    in_ready   = (count_q < CW'(DEPTH));
    RegWrite   = (count_q != '0);
    write_reg  = RegWrite ? ent_reg_q[rd_ptr_q]  : '0;
    write_data = RegWrite ? ent_data_q[rd_ptr_q] : '0;
    pop        = RegWrite && wr_grant;
    // $0 transfers complete the handshake but are never stored.
    push       = in_valid && in_ready && (in_reg != '0);
  end

  // Next-state: flush wins over push/pop; pointers wrap by natural overflow.
  always_comb begin
    ent_reg_d  = ent_reg_q;
    ent_data_d = ent_data_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        ent_reg_d[wr_ptr_q]  = in_reg;
        ent_data_d[wr_ptr_q] = in_mem_to_reg ? in_mem_data : in_alu_result;
        wr_ptr_d             = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Forwarding: walk oldest to youngest so the last match wins.
  always_comb begin
    logic [PW-1:0] idx;
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = '0;
    fwd_data2 = '0;
    idx       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if (CW'(i) < count_q) begin
        if (fwd_reg1 != '0 && ent_reg_q[idx] == fwd_reg1) begin
          fwd_hit1  = 1'b1;
          fwd_data1 = ent_data_q[idx];
        end
        if (fwd_reg2 != '0 && ent_reg_q[idx] == fwd_reg2) begin
          fwd_hit2  = 1'b1;
          fwd_data2 = ent_data_q[idx];
        end
      end
    end
  end

  // State register with synchronous reset; reset drops all pending entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_reg_q[i]  <= '0;
        ent_data_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      ent_reg_q  <= ent_reg_d;
      ent_data_q <= ent_data_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

endmodule

// File: tb/tb_rf_write_queue.sv
// Bench for rf_write_queue: directed scenarios then random traffic, all
// checked every cycle against a queue-based reference model.
module tb_rf_write_queue;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_reg;
  logic              in_mem_to_reg;
  logic [DATA_W-1:0] in_alu_result;
  logic [DATA_W-1:0] in_mem_data;
  logic              flush;
  logic              wr_grant;
  logic              RegWrite;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic [ADDR_W-1:0] fwd_reg1, fwd_reg2;
  logic              fwd_hit1, fwd_hit2;
  logic [DATA_W-1:0] fwd_data1, fwd_data2;
  logic [$clog2(DEPTH):0] count;

  rf_write_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg),
    .in_mem_to_reg(in_mem_to_reg), .in_alu_result(in_alu_result),
    .in_mem_data(in_mem_data), .flush(flush), .wr_grant(wr_grant),
    .RegWrite(RegWrite), .write_reg(write_reg), .write_data(write_data),
    .fwd_reg1(fwd_reg1), .fwd_reg2(fwd_reg2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] r;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t mq[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_writes = 0;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                     input logic [DATA_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference lookup: youngest pending entry naming register r.
  task automatic model_fwd(input logic [ADDR_W-1:0] r, output logic hit,
                           output logic [DATA_W-1:0] d);
    hit = 1'b0;
    d   = '0;
    if (r != 0)
      for (int i = mq.size() - 1; i >= 0; i--)
        if (mq[i].r == r) begin
          hit = 1'b1;
          d   = mq[i].d;
          break;
        end
  endtask

  // One clock: drive inputs, check outputs at the falling edge, then
  // advance the model at the rising edge.
  task automatic cyc(input logic v, input logic [ADDR_W-1:0] r, input logic m,
                     input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] md,
                     input logic fl, input logic gr,
                     input logic [ADDR_W-1:0] f1, input logic [ADDR_W-1:0] f2,
                     input logic rs);
    logic h;
    logic [DATA_W-1:0] d;
    int   sz;
    ent_t e;
    rst = rs; in_valid = v; in_reg = r; in_mem_to_reg = m;
    in_alu_result = a; in_mem_data = md; flush = fl; wr_grant = gr;
    fwd_reg1 = f1; fwd_reg2 = f2;
    @(negedge clk);
    sz = mq.size();
    chk("in_ready", 32'(in_ready), 32'(sz < DEPTH));
    chk("count", 32'(count), 32'(sz));
    chk("RegWrite", 32'(RegWrite), 32'(sz != 0));
    chk("write_reg", 32'(write_reg), sz != 0 ? 32'(mq[0].r) : 32'd0);
    chk("write_data", write_data, sz != 0 ? mq[0].d : 32'd0);
    model_fwd(f1, h, d);
    chk("fwd_hit1", 32'(fwd_hit1), 32'(h));
    chk("fwd_data1", fwd_data1, d);
    model_fwd(f2, h, d);
    chk("fwd_hit2", 32'(fwd_hit2), 32'(h));
    chk("fwd_data2", fwd_data2, d);
    @(posedge clk);
    if (rs || fl) mq.delete();
    else begin
      if (sz != 0 && gr) begin
        void'(mq.pop_front());
        n_writes++;
      end
      if (v && sz < DEPTH && r != 0) begin
        e.r = r;
        e.d = m ? md : a;
        mq.push_back(e);
      end
    end
    #1;
  endtask

  task automatic idle(input logic gr, input logic [ADDR_W-1:0] f1,
                      input logic [ADDR_W-1:0] f2);
    cyc(1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 1'b0, gr, f1, f2, 1'b0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; in_reg = 0; in_mem_to_reg = 0;
    in_alu_result = 0; in_mem_data = 0; flush = 0; wr_grant = 0;
    fwd_reg1 = 0; fwd_reg2 = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Reset state and single ALU write.
    idle(1'b0, 5'd5, 5'd0);
    cyc(1, 5'd5, 0, 32'h0000_1234, 32'h9999_9999, 0, 1, 5'd5, 5'd0, 0);
    idle(1'b1, 5'd5, 5'd0);
    idle(1'b1, 5'd5, 5'd0);

    // Load select and $0 drop.
    cyc(1, 5'd0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 5'd0, 5'd8, 0);
    cyc(1, 5'd8, 1, 32'h1, 32'hDEAD_BEEF, 0, 0, 5'd0, 5'd8, 0);
    idle(1'b1, 5'd8, 5'd0);
    idle(1'b1, 5'd8, 5'd0);

    // Fill, back-pressure, then drain in order.
    for (int i = 1; i <= 4; i++)
      cyc(1, 5'(i), 0, 32'(i * 16), 32'd0, 0, 0, 5'd2, 5'd4, 0);
    cyc(1, 5'd9, 0, 32'h55, 32'd0, 0, 0, 5'd9, 5'd1, 0);
    cyc(1, 5'd9, 0, 32'h55, 32'd0, 0, 1, 5'd9, 5'd1, 0);
    for (int i = 0; i < 5; i++) idle(1'b1, 5'd9, 5'd3);

    // Youngest forwarding.
    cyc(1, 5'd7, 0, 32'hA, 32'd0, 0, 0, 5'd7, 5'd0, 0);
    cyc(1, 5'd7, 0, 32'hB, 32'd0, 0, 0, 5'd7, 5'd0, 0);
    idle(1'b0, 5'd7, 5'd0);
    for (int i = 0; i < 3; i++) idle(1'b1, 5'd7, 5'd0);

    // Flush beats push and pop in the same cycle.
    for (int i = 0; i < 3; i++)
      cyc(1, 5'(10 + i), 0, 32'(100 + i), 32'd0, 0, 0, 5'd11, 5'd12, 0);
    cyc(1, 5'd13, 0, 32'h77, 32'd0, 1, 1, 5'd11, 5'd12, 0);
    idle(1'b1, 5'd11, 5'd13);
    idle(1'b1, 5'd11, 5'd13);

    // Pointer wrap-around: 10 pushes with alternating grant, then drain.
    for (int i = 0; i < 10; i++)
      cyc(1, 5'(16 + i), i[0], 32'(i * 3 + 1), 32'hC000_0000 | 32'(i), 0,
          i[0], 5'(16 + i), 5'(15 + i), 0);
    for (int i = 0; i < 12; i++) idle(1'b1, 5'd20, 5'd25);

    // Random traffic with occasional flush and mid-operation reset.
    for (int i = 0; i < 600; i++)
      cyc(($urandom % 4) != 0, 5'($urandom % 8), 1'($urandom), $urandom,
          $urandom, ($urandom % 32) == 0, 1'($urandom),
          5'($urandom % 8), 5'($urandom % 8), ($urandom % 64) == 0);
    for (int i = 0; i < 6; i++) idle(1'b1, 5'd1, 5'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
